// File: rtl/sdf_ctrl_pkg.sv
// Shared definitions for the SDF NTT scheduler: FSM state encoding and a
// constant-width helper used to size the RUN cycle counter.
package sdf_ctrl_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } sched_state_t;

    // Smallest width w with 2**w >= value (returns at least 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sdf_coef_buf.sv
// N x DATA_WIDTH simple dual-port coefficient buffer: synchronous write,
// combinational read from an address the caller keeps in a register.
module sdf_coef_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int N          = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sdf_ntt_scheduler.sv
// Per-polynomial sequencer for one SDF NTT pipeline: collect N words, burst them
// into the SDF with a start pulse, capture N results at fixed latency, replay them.
module sdf_ntt_scheduler
    import sdf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int N           = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int SDF_LATENCY = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] sdf_in,
    output logic                  sdf_start,
    input  logic [DATA_WIDTH-1:0] sdf_out,
    input  logic                  sdf_done_tick,
    output logic                  busy,
    output logic                  err_sync
);

    localparam int CYC_W = clog2(SDF_LATENCY + N);

    localparam logic [CYC_W-1:0]      FEED_LAST = CYC_W'(N - 1);
    localparam logic [CYC_W-1:0]      CAP_FIRST = CYC_W'(SDF_LATENCY);
    localparam logic [CYC_W-1:0]      CAP_LAST  = CYC_W'(SDF_LATENCY + N - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(N - 1);

    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_IDX) ? '0 : a + 1'b1;
    endfunction

    sched_state_t          state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [CYC_W-1:0]      cyc;
    logic [ADDR_WIDTH-1:0] in_rd_addr;
    logic [ADDR_WIDTH-1:0] out_rd_addr;

    logic                  in_accept;
    logic                  out_fire;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] in_rd_data;
    logic [DATA_WIDTH-1:0] out_rd_data;

    // Valid/ready: a word moves only in a cycle where both valid and ready are
    // high at the rising edge; valid never waits on ready, and a presented word
    // (data and last) holds unchanged until it is taken.
    assign in_accept = in_ready && in_valid;
    assign out_fire  = out_valid && out_ready;
    assign capture   = (state == S_RUN) && (cyc >= CAP_FIRST) && (cyc <= CAP_LAST);
    assign cap_addr  = ADDR_WIDTH'(cyc - CAP_FIRST);

    sdf_coef_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_in_buf (
        .clk     (clk),
        .wr_en   (in_accept),
        .wr_addr (wr_cnt),
        .wr_data (in_data),
        .rd_addr (in_rd_addr),
        .rd_data (in_rd_data)
    );

    sdf_coef_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .wr_en   (capture),
        .wr_addr (cap_addr),
        .wr_data (sdf_out),
        .rd_addr (out_rd_addr),
        .rd_data (out_rd_data)
    );

    // Read addresses run one word ahead of the registered outputs, so each
    // output register loads the next word on the same edge it is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FILL;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            cyc         <= '0;
            in_rd_addr  <= '0;
            out_rd_addr <= '0;
            in_ready    <= 1'b1;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            sdf_in      <= '0;
            sdf_start   <= 1'b0;
            busy        <= 1'b0;
            err_sync    <= 1'b0;
        end else begin
            sdf_start <= 1'b0;
            case (state)
                S_FILL: begin
                    if (in_accept) begin
                        if (wr_cnt == LAST_IDX) begin
                            wr_cnt     <= '0;
                            state      <= S_RUN;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                            cyc        <= '0;
                            sdf_start  <= 1'b1;
                            sdf_in     <= in_rd_data;
                            in_rd_addr <= wrap_inc(in_rd_addr);
                        end else begin
                            wr_cnt <= wrap_inc(wr_cnt);
                        end
                    end
                end

                S_RUN: begin
                    if (cyc < FEED_LAST) begin
                        sdf_in     <= in_rd_data;
                        in_rd_addr <= wrap_inc(in_rd_addr);
                    end else begin
                        sdf_in <= '0;
                    end

                    // The SDF cannot stall: its done tick must land on the last capture.
                    if (sdf_done_tick != (cyc == CAP_LAST)) begin
                        err_sync <= 1'b1;
                    end

                    if (cyc == CAP_LAST) begin
                        cyc         <= '0;
                        state       <= S_DRAIN;
                        rd_cnt      <= '0;
                        out_valid   <= 1'b1;
                        out_data    <= out_rd_data;
                        out_last    <= (LAST_IDX == '0);
                        out_rd_addr <= wrap_inc(out_rd_addr);
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (out_fire) begin
                        if (out_last) begin
                            state     <= S_FILL;
                            rd_cnt    <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            rd_cnt      <= wrap_inc(rd_cnt);
                            out_data    <= out_rd_data;
                            out_last    <= (wrap_inc(rd_cnt) == LAST_IDX);
                            out_rd_addr <= wrap_inc(out_rd_addr);
                        end
                    end
                end

                default: begin
                    state    <= S_FILL;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdf_ntt_scheduler.sv
// Directed bench for sdf_ntt_scheduler with a behavioural SDF model
// (out = in + 1000, fixed latency, done tick on the last result word).
module tb_sdf_ntt_scheduler;

    localparam int DW  = 64;
    localparam int N   = 8;
    localparam int AW  = 3;
    localparam int LAT = 10;

    logic          clk_tb = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [DW-1:0] sdf_in;
    logic          sdf_start;
    logic [DW-1:0] sdf_out;
    logic          sdf_done_tick;
    logic          busy;
    logic          err_sync;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_q[$];

    always #5 clk_tb = ~clk_tb;

    sdf_ntt_scheduler #(
        .DATA_WIDTH  (DW),
        .N           (N),
        .ADDR_WIDTH  (AW),
        .SDF_LATENCY (LAT)
    ) dut (
        .clk           (clk_tb),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .sdf_in        (sdf_in),
        .sdf_start     (sdf_start),
        .sdf_out       (sdf_out),
        .sdf_done_tick (sdf_done_tick),
        .busy          (busy),
        .err_sync      (err_sync)
    );

    // Behavioural SDF: data delay line of LAT stages, start delay line of LAT+N-1.
    logic [DW-1:0]      pipe [LAT];
    logic [LAT+N-2:0]   st_pipe = '0;
    logic               early_tick = 1'b0;

    always @(posedge clk_tb) begin
        pipe[0] <= sdf_in;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        st_pipe <= {st_pipe[LAT+N-3:0], sdf_start};
    end

    assign sdf_out       = pipe[LAT-1] + 64'd1000;
    assign sdf_done_tick = early_tick ? st_pipe[LAT+N-3] : st_pipe[LAT+N-2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Feed words base+first .. base+N-1, one valid cycle then one idle cycle each.
    // Returns on the negedge of RUN cycle 0.
    task automatic load_gappy(input logic [63:0] base, input int first);
        for (int i = first; i < N; i++) begin
            @(negedge clk_tb);
            chk("load_in_ready", in_ready, 1);
            chk("load_no_start", sdf_start, 0);
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            @(negedge clk_tb);
            in_valid = 1'b0;
        end
    endtask

    // Checks the burst into the SDF and the fixed latency to the first output word.
    task automatic run_check(input logic [63:0] base);
        chk("run_start_c0", sdf_start, 1);
        chk("run_sdf_in_c0", sdf_in, base);
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
        for (int k = 1; k < N; k++) begin
            @(negedge clk_tb);
            chk("run_start_low", sdf_start, 0);
            chk("run_sdf_in_seq", sdf_in, base + 64'(k));
        end
        @(negedge clk_tb);
        chk("run_sdf_in_idle", sdf_in, 0);
        for (int k = N + 1; k < LAT + N; k++) @(negedge clk_tb);
        chk("run_no_out_valid", out_valid, 0);
        @(negedge clk_tb);
        chk("drain_entry_valid", out_valid, 1);
    endtask

    // Drains one polynomial against the expected queue; bp selects 1,0,0,1 out_ready.
    task automatic drain(input logic [63:0] base, input logic bp);
        int cycles;
        int pat;
        exp_q = {};
        for (int j = 0; j < N; j++) exp_q.push_back(base + 64'd1000 + 64'(j));
        cycles = 0;
        pat    = 0;
        while (exp_q.size() > 0 && cycles < 100) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, exp_q[0]);
            chk("drain_last", out_last, (exp_q.size() == 1) ? 64'd1 : 64'd0);
            chk("drain_in_ready", in_ready, 0);
            out_ready = bp ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'b1;
            if (out_ready) void'(exp_q.pop_front());
            pat++;
            cycles++;
            @(negedge clk_tb);
        end
        chk("drain_complete", 64'(exp_q.size()), 0);
        out_ready = 1'b0;
        chk("fill_in_ready", in_ready, 1);
        chk("fill_out_valid", out_valid, 0);
        chk("fill_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_tb);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sdf_start", sdf_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_sync", err_sync, 0);
        chk("rst_sdf_in", sdf_in, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;

        // Gappy load, burst, capture, full-rate drain
        load_gappy(64'd1, 0);
        run_check(64'd1);
        drain(64'd1, 1'b0);
        chk("clean_err_sync", err_sync, 0);

        // Backpressure on the output stream
        load_gappy(64'd17, 0);
        run_check(64'd17);
        drain(64'd17, 1'b1);
        chk("bp_err_sync", err_sync, 0);

        // Early done tick sets a sticky error
        early_tick = 1'b1;
        load_gappy(64'd33, 0);
        run_check(64'd33);
        drain(64'd33, 1'b0);
        chk("sync_err_set", err_sync, 1);
        early_tick = 1'b0;

        // Clean polynomial keeps the error, then reset two cycles mid-drain
        load_gappy(64'd41, 0);
        run_check(64'd41);
        chk("sync_err_held", err_sync, 1);
        out_ready = 1'b1;
        chk("mid_drain_w0", out_data, 64'd1041);
        repeat (2) @(negedge clk_tb);
        chk("mid_drain_w2", out_data, 64'd1043);
        rst       = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk_tb);
        rst = 1'b0;
        @(negedge clk_tb);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_out_last", out_last, 0);
        chk("rst2_err_sync", err_sync, 0);
        chk("rst2_busy", busy, 0);

        // Back-to-back: word 9 held valid from RUN onward, taken only after out_last
        load_gappy(64'd1, 0);
        in_valid = 1'b1;
        in_data  = 64'd9;
        run_check(64'd1);
        drain(64'd1, 1'b0);
        load_gappy(64'd9, 1);
        run_check(64'd9);
        drain(64'd9, 1'b0);
        chk("b2b_err_sync", err_sync, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
